// File: rtl/usb_ep_out_buffer_pkg.sv
// usbPkg: definitions shared between the OUT endpoint buffer and the USB
// protocol engine.
//   ep_state_t  : OUT endpoint receive FSM states (IDLE/RECV/DROP)
//   PID_DATA0/1 : data-toggle values carried by the data PID
//   USB_MAX_PKT : default max payload bytes per packet
package usbPkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } ep_state_t;

  localparam logic PID_DATA0 = 1'b0;
  localparam logic PID_DATA1 = 1'b1;

  localparam int unsigned USB_MAX_PKT = 8;

endpackage

// File: rtl/usb_ep_out_buffer_mem.sv
// usb_ep_out_mem: simple dual-port RAM, WIDTH x DEPTH.
//   clk     : clock
//   wr_en   : write strobe, synchronous write of wr_data at wr_addr
//   rd_addr : read address
//   rd_data : registered read data (returns old contents on same-address write)
module usb_ep_out_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/usb_ep_out_buffer.sv
// usb_ep_out_buffer: per-endpoint USB OUT receive buffer.
// Accepts an OUT token when a full packet fits, stores granted payload bytes
// speculatively, commits on a good end with the expected data toggle and rolls
// back otherwise. Committed bytes leave on a first-word-fall-through
// valid/ready stream.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_tokenOut            : OUT token for this endpoint (pulse)
//   i_rxValid, i_rxData   : payload byte strobe and data
//   i_rxPid1              : packet data PID (1 = DATA1), valid with i_rxEnd
//   i_rxEnd, i_rxFail     : packet end with good CRC / packet aborted (pulses)
//   o_req, i_grant        : arbiter request and grant
//   o_ack, o_nak          : handshake requests to the protocol engine (pulses)
//   o_data, o_valid,
//   i_ready               : committed data stream to the application
//   o_occupancy           : committed occupancy, registered; only present when
//                           USB_EP_OUT_BUFFER_OCCUPANCY_EN is defined
module usb_ep_out_buffer
  import usbPkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned MAX_PKT = USB_MAX_PKT,
  parameter int unsigned WIDTH   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_tokenOut,
  input  logic                     i_rxValid,
  input  logic [WIDTH-1:0]         i_rxData,
  input  logic                     i_rxPid1,
  input  logic                     i_rxEnd,
  input  logic                     i_rxFail,
  output logic                     o_req,
  input  logic                     i_grant,
  output logic                     o_ack,
  output logic                     o_nak,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready
`ifdef USB_EP_OUT_BUFFER_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0]   o_occupancy
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(MAX_PKT + 1);

  ep_state_t        state;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_commit;
  logic [PW-1:0]    wr_spec;
  logic [PW-1:0]    rd_ptr_next;
  logic [PW-1:0]    occupancy;
  logic [PW-1:0]    free_space;
  logic [CW-1:0]    byte_cnt;
  logic             overflow;
  logic             toggle;
  logic             room;
  logic             rd_fire;
  logic             wr_en;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    occupancy   = wr_commit - rd_ptr;
    free_space  = PW'(DEPTH) - (wr_spec - rd_ptr);
    room        = free_space >= PW'(MAX_PKT);
    o_valid     = occupancy != '0;
    rd_fire     = o_valid && i_ready;
    rd_ptr_next = rd_ptr + PW'(rd_fire);
    o_data      = o_valid ? rd_data : '0;
    // A byte coincident with end/fail is not part of the packet; this keeps
    // every committed byte at least one cycle old, so the registered read of
    // the head is never stale when o_valid rises.
    wr_en       = (state == RECV) && i_grant && i_rxValid && !i_rxEnd &&
                  !i_rxFail && (byte_cnt != CW'(MAX_PKT));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_commit <= '0;
      wr_spec   <= '0;
      byte_cnt  <= '0;
      overflow  <= 1'b0;
      toggle    <= PID_DATA0;
      o_req     <= 1'b0;
      o_ack     <= 1'b0;
      o_nak     <= 1'b0;
    end else begin
      o_ack  <= 1'b0;
      o_nak  <= 1'b0;
      rd_ptr <= rd_ptr_next;
      case (state)
        IDLE: begin
          if (i_tokenOut) begin
            if (room) begin
              state    <= RECV;
              o_req    <= 1'b1;
              wr_spec  <= wr_commit;
              byte_cnt <= '0;
              overflow <= 1'b0;
            end else begin
              state <= DROP;
              o_nak <= 1'b1;
            end
          end
        end
        RECV: begin
          if (i_rxFail || i_rxEnd) begin
            state <= IDLE;
            o_req <= 1'b0;
            if (!i_rxFail && !overflow && (i_rxPid1 == toggle)) begin
              wr_commit <= wr_spec;
              toggle    <= (toggle == PID_DATA0) ? PID_DATA1 : PID_DATA0;
            end else begin
              wr_spec <= wr_commit;
            end
            // A duplicate (toggle mismatch) is still acknowledged so the host
            // can advance; oversize or aborted packets are not.
            o_ack <= !i_rxFail && !overflow;
          end else if (i_grant && i_rxValid) begin
            if (byte_cnt == CW'(MAX_PKT)) begin
              overflow <= 1'b1;
            end else begin
              wr_spec  <= wr_spec + PW'(1);
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        DROP: begin
          if (i_rxEnd || i_rxFail) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USB_EP_OUT_BUFFER_OCCUPANCY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_occupancy <= '0;
    end else begin
      o_occupancy <= occupancy;
    end
  end
`endif

  usb_ep_out_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_spec[AW-1:0]),
    .wr_data (i_rxData),
    .rd_addr (rd_ptr_next[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_usb_ep_out_buffer.sv
// Testbench for usb_ep_out_buffer: table of directed packets, hand-written
// fill/reset sequences and randomized packets checked against a queue model.
// Connects o_occupancy when USB_EP_OUT_BUFFER_OCCUPANCY_EN is defined.
module tb_usb_ep_out_buffer;

  localparam int DEPTH   = 64;
  localparam int MAX_PKT = 8;

  logic       i_clk = 1'b0;
  logic       i_rst, i_tokenOut, i_rxValid, i_rxPid1, i_rxEnd, i_rxFail;
  logic [7:0] i_rxData;
  logic       i_grant, i_ready;
  logic       o_req, o_ack, o_nak, o_valid;
  logic [7:0] o_data;
`ifdef USB_EP_OUT_BUFFER_OCCUPANCY_EN
  logic [6:0] o_occupancy;
`endif

  usb_ep_out_buffer #(
    .DEPTH   (DEPTH),
    .MAX_PKT (MAX_PKT),
    .WIDTH   (8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tokenOut (i_tokenOut),
    .i_rxValid  (i_rxValid),
    .i_rxData   (i_rxData),
    .i_rxPid1   (i_rxPid1),
    .i_rxEnd    (i_rxEnd),
    .i_rxFail   (i_rxFail),
    .o_req      (o_req),
    .i_grant    (i_grant),
    .o_ack      (o_ack),
    .o_nak      (o_nak),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
`ifdef USB_EP_OUT_BUFFER_OCCUPANCY_EN
    ,
    .o_occupancy (o_occupancy)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Reference model: committed bytes awaiting the consumer, expected toggle.
  logic [7:0] m_q[$];
  bit         m_toggle;
  bit         exp_req, exp_ack, exp_nak;
  int         ready_mode;   // 0: hold low, 1: hold high, 2: random
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int       n;      // payload bytes strobed
    bit [7:0] base;   // first byte value, then incrementing
    bit       pid;    // data PID
    int       fail;   // 0: rxEnd, 1: rxFail, 2: both
    int       ungr;   // leading bytes strobed without grant
    bit       drain;  // read everything out afterwards
    bit       ack;    // expected o_ack pulse
    bit       nak;    // expected o_nak pulse
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: check the read handshake about to happen, clock, then check
  // registered outputs and pick the next ready value.
  task automatic tick();
    bit         fire;
    logic [7:0] d;
    int         pre;
    bit         rst_edge;
    pre      = m_q.size();
    rst_edge = i_rst;
    chk("valid", o_valid, (m_q.size() != 0));
    fire = (o_valid === 1'b1) && i_ready;
    d    = o_data;
    if (fire && m_q.size() > 0) begin
      chk("rd_data", d, m_q[0]);
      void'(m_q.pop_front());
    end
    @(posedge i_clk);
    #1;
    chk("req", o_req, exp_req);
    chk("ack", o_ack, exp_ack);
    chk("nak", o_nak, exp_nak);
`ifdef USB_EP_OUT_BUFFER_OCCUPANCY_EN
    if (!rst_edge) chk("occupancy", o_occupancy, pre);
`else
    if (rst_edge && pre < 0) chk("unused", 0, 1);
`endif
    exp_ack = 1'b0;
    exp_nak = 1'b0;
    i_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  endtask

  task automatic drain();
    ready_mode = 1;
    i_ready    = 1'b1;
    for (int i = 0; i < 4 * DEPTH && m_q.size() != 0; i++) tick();
    chk("drain_done", m_q.size(), 0);
    tick();
  endtask

  task automatic send_pkt(input int n, input bit [7:0] base, input bit pid,
                          input int fail, input int ungr, input bit rnd,
                          input bit use_tbl, input bit t_ack, input bit t_nak);
    bit         accept, gr, good;
    int         cnt;
    logic [7:0] pend[$];
    cnt    = 0;
    accept = (DEPTH - m_q.size()) >= MAX_PKT;
    i_tokenOut = 1'b1;
    exp_req    = accept;
    exp_nak    = use_tbl ? t_nak : !accept;
    i_grant    = 1'b0;
    tick();
    i_tokenOut = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        i_rxValid = 1'b0;
        i_grant   = accept;
        tick();
      end
      gr = (i >= ungr) && (!rnd || $urandom_range(0, 4) != 0);
      i_rxValid = 1'b1;
      i_rxData  = base + 8'(i);
      i_grant   = gr && accept;
      if (gr && accept) begin
        cnt++;
        if (cnt <= MAX_PKT) pend.push_back(base + 8'(i));
      end
      tick();
    end
    i_rxValid = 1'b0;
    i_rxPid1  = pid;
    i_rxEnd   = (fail != 1);
    i_rxFail  = (fail != 0);
    good      = accept && (fail == 0) && (cnt <= MAX_PKT);
    exp_ack   = use_tbl ? t_ack : good;
    exp_req   = 1'b0;
    tick();
    i_rxEnd  = 1'b0;
    i_rxFail = 1'b0;
    i_grant  = 1'b0;
    if (good && pid == m_toggle) begin
      foreach (pend[k]) m_q.push_back(pend[k]);
      m_toggle = !m_toggle;
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8, 8'h00, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};  // first DATA0 packet
    tbl[1] = '{8, 8'h00, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};  // duplicate, acked only
    tbl[2] = '{5, 8'h20, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0};  // aborted
    tbl[3] = '{4, 8'h30, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0};  // own bytes only
    tbl[4] = '{7, 8'h40, 1'b0, 0, 3, 1'b1, 1'b1, 1'b0};  // 3 ungranted first
    tbl[5] = '{0, 8'h00, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0};  // zero-length
    tbl[6] = '{9, 8'h50, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};  // oversize
    tbl[7] = '{8, 8'h60, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};  // toggle unchanged by 6
    tbl[8] = '{3, 8'h70, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0};  // end+fail: fail wins
    tbl[9] = '{2, 8'h78, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0};

    i_rst = 1'b1; i_tokenOut = 1'b0; i_rxValid = 1'b0; i_rxData = '0;
    i_rxPid1 = 1'b0; i_rxEnd = 1'b0; i_rxFail = 1'b0; i_grant = 1'b0;
    i_ready = 1'b0; ready_mode = 0; m_toggle = 1'b0;
    exp_req = 1'b0; exp_ack = 1'b0; exp_nak = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_req", o_req, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_nak", o_nak, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    i_rst = 1'b0;
    tick();

    for (int v = 0; v < 10; v++) begin
      ready_mode = 0;
      i_ready    = 1'b0;
      send_pkt(tbl[v].n, tbl[v].base, tbl[v].pid, tbl[v].fail, tbl[v].ungr,
               1'b0, 1'b1, tbl[v].ack, tbl[v].nak);
      if (tbl[v].drain) drain();
    end

    // Fill to DEPTH-4 committed, then a token must be NAKed and its bytes ignored.
    ready_mode = 0;
    i_ready    = 1'b0;
    for (int p = 0; p < 7; p++) send_pkt(8, 8'(8 * p), m_toggle, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(4, 8'hA0, m_toggle, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill_level", m_q.size(), DEPTH - 4);
    send_pkt(6, 8'hB0, m_toggle, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    send_pkt(3, 8'hC0, m_toggle, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // Committed data plus a partial packet, then reset mid-RECV.
    ready_mode = 0;
    i_ready    = 1'b0;
    send_pkt(3, 8'hD0, m_toggle, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_tokenOut = 1'b1;
    exp_req    = 1'b1;
    tick();
    i_tokenOut = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_rxValid = 1'b1;
      i_rxData  = 8'hE0 + 8'(i);
      i_grant   = 1'b1;
      tick();
    end
    i_rxValid = 1'b0;
    i_grant   = 1'b0;
    i_rst     = 1'b1;
    exp_req   = 1'b0;
    tick();
    i_rst = 1'b0;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_data", o_data, 0);
    m_q.delete();
    m_toggle = 1'b0;
    send_pkt(2, 8'hF0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("post_rst_level", m_q.size(), 2);
    drain();

    // Randomized packets with random grant gaps, toggles, failures and reads.
    for (int k = 0; k < 60; k++) begin
      int  n, f, r;
      bit  pid;
      ready_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(1, 8));
      pid = ($urandom_range(0, 4) == 0) ? !m_toggle : m_toggle;
      r   = $urandom_range(0, 19);
      f   = (r < 2) ? 1 : (r < 3) ? 2 : 0;
      send_pkt(n, 8'($urandom_range(0, 255)), pid, f, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
